// File: rtl/muldiv_pkg.sv
// muldiv_pkg
//   Shared definitions for the HI/LO multiply/divide sequencer:
//   operation encodings, FSM state enum, default operand width and
//   small decode helpers for the op field.
package muldiv_pkg;

   localparam int MD_WIDTH = 32;

   typedef enum logic [1:0] {
      MD_MULT  = 2'b00,
      MD_MULTU = 2'b01,
      MD_DIV   = 2'b10,
      MD_DIVU  = 2'b11
   } md_op_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_FIX,
      ST_DONE
   } md_state_e;

   function automatic logic md_is_div(input md_op_e op);
      return (op == MD_DIV) || (op == MD_DIVU);
   endfunction

   function automatic logic md_is_signed(input md_op_e op);
      return (op == MD_MULT) || (op == MD_DIV);
   endfunction

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step
//   One combinational iteration of the shared multiply/divide datapath.
//   Ports:
//     is_div   - 1: restoring-divide step, 0: shift-add multiply step
//     hi_in    - upper accumulator half (product high / partial remainder)
//     lo_in    - lower accumulator half (multiplier bits / dividend-quotient)
//     operand  - multiplicand magnitude (mult) or divisor magnitude (div)
//     hi_out, lo_out - accumulator after this iteration
module muldiv_step
   import muldiv_pkg::*;
#(
   parameter int WIDTH = MD_WIDTH
) (
   input  logic             is_div,
   input  logic [WIDTH-1:0] hi_in,
   input  logic [WIDTH-1:0] lo_in,
   input  logic [WIDTH-1:0] operand,
   output logic [WIDTH-1:0] hi_out,
   output logic [WIDTH-1:0] lo_out
);

   logic [WIDTH:0]   sum;       // add with carry-out for the multiply step
   logic [WIDTH:0]   shifted;   // partial remainder shifted left, one extra bit
   logic             no_borrow;
   logic [WIDTH-1:0] diff;

   always_comb begin
      sum       = {1'b0, hi_in} + (lo_in[0] ? {1'b0, operand} : '0);
      shifted   = {hi_in, lo_in[WIDTH-1]};
      no_borrow = (shifted >= {1'b0, operand});
      // When the subtraction succeeds the remainder is below the divisor,
      // so the low WIDTH bits of the difference hold it exactly.
      diff      = shifted[WIDTH-1:0] - operand;

      hi_out = '0;
      lo_out = '0;
      if (is_div) begin
         hi_out = no_borrow ? diff : shifted[WIDTH-1:0];
         lo_out = {lo_in[WIDTH-2:0], no_borrow};
      end else begin
         // {sum, lo_in} shifted right by one: the carry lands in hi_out MSB
         hi_out = sum[WIDTH:1];
         lo_out = {sum[0], lo_in[WIDTH-1:1]};
      end
   end

endmodule

// File: rtl/muldiv_hilo_ctrl.sv
// muldiv_hilo_ctrl
//   Multi-cycle MULT/MULTU/DIV/DIVU sequencer owning the architectural
//   HI/LO registers. One iteration per cycle: IDLE -> RUN (WIDTH cycles)
//   -> FIX (sign correction, result load) -> DONE (done pulse) -> IDLE.
//   Ports:
//     clk, rst             - clock, synchronous active-high reset
//     flush                - abort in-flight op, return to IDLE, HI/LO kept
//     req_valid/req_ready  - request handshake (ready only in IDLE)
//     req_op, req_a, req_b - operation and operands (rs, rt)
//     wr_hi_en, wr_lo_en, wr_data - MTHI/MTLO writes (honoured in IDLE/DONE)
//     busy, done           - RUN/FIX indicator, one-cycle completion pulse
//     hi, lo               - architectural HI/LO
//     ovf                  - signed divide of most-negative by -1
//     dz                   - divide-by-zero flag
//   Build option: define MULDIV_DZ_EN to short-circuit divide-by-zero
//   (skip RUN, HI = a, LO = all ones, dz = 1). Without it dz is tied low
//   and b == 0 runs the normal algorithm.
module muldiv_hilo_ctrl
   import muldiv_pkg::*;
#(
   parameter int WIDTH = MD_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [1:0]       req_op,
   input  logic [WIDTH-1:0] req_a,
   input  logic [WIDTH-1:0] req_b,
   input  logic             wr_hi_en,
   input  logic             wr_lo_en,
   input  logic [WIDTH-1:0] wr_data,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             ovf,
   output logic             dz
);

   localparam int CW = $clog2(WIDTH);

   md_state_e        state_reg, state_next;
   logic [CW-1:0]    cnt_reg;
   logic [WIDTH-1:0] acc_hi_reg, acc_lo_reg, mag_op_reg;
   logic [WIDTH-1:0] hi_reg, lo_reg;
   logic             op_is_div_reg, neg_res_reg, neg_rem_reg;
   logic             ovf_pend_reg, ovf_reg, dz_pend_reg;

   // Request decode
   md_op_e           op_in;
   logic             in_signed, in_div, sign_a, sign_b, accept, dz_hit;
   logic [WIDTH-1:0] mag_a, mag_b;

   // Datapath step and sign correction
   logic [WIDTH-1:0]   step_hi, step_lo;
   logic [2*WIDTH-1:0] product, prod_fix;
   logic [WIDTH-1:0]   res_hi, res_lo;
   logic               wr_allowed;

   assign op_in     = md_op_e'(req_op);
   assign in_signed = md_is_signed(op_in);
   assign in_div    = md_is_div(op_in);
   assign sign_a    = in_signed & req_a[WIDTH-1];
   assign sign_b    = in_signed & req_b[WIDTH-1];
   // Two's complement negation leaves the most-negative value unchanged,
   // which is exactly the unsigned magnitude 2^(WIDTH-1).
   assign mag_a     = sign_a ? (-req_a) : req_a;
   assign mag_b     = sign_b ? (-req_b) : req_b;
   assign accept    = req_valid && (state_reg == ST_IDLE) && !flush;
   assign wr_allowed = ((state_reg == ST_IDLE) || (state_reg == ST_DONE)) && !flush;

`ifdef MULDIV_DZ_EN
   assign dz_hit = in_div && (req_b == '0);
`else
   assign dz_hit = 1'b0;
`endif

   muldiv_step #(.WIDTH(WIDTH)) u_step (
      .is_div  (op_is_div_reg),
      .hi_in   (acc_hi_reg),
      .lo_in   (acc_lo_reg),
      .operand (mag_op_reg),
      .hi_out  (step_hi),
      .lo_out  (step_lo)
   );

   assign product = {acc_hi_reg, acc_lo_reg};

   always_comb begin
      prod_fix = neg_res_reg ? (-product) : product;
      res_hi   = prod_fix[2*WIDTH-1:WIDTH];
      res_lo   = prod_fix[WIDTH-1:0];
      if (dz_pend_reg) begin
         // Accumulator was preloaded with the raw dividend and all ones.
         res_hi = acc_hi_reg;
         res_lo = acc_lo_reg;
      end else if (op_is_div_reg) begin
         res_lo = neg_res_reg ? (-acc_lo_reg) : acc_lo_reg;
         res_hi = neg_rem_reg ? (-acc_hi_reg) : acc_hi_reg;
      end
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // FSM next state and state-decoded outputs
   always_comb begin
      state_next = state_reg;
      req_ready  = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            req_ready = 1'b1;
            if (accept) begin
               state_next = dz_hit ? ST_FIX : ST_RUN;
            end
         end
         ST_RUN: begin
            busy = 1'b1;
            if (cnt_reg == CW'(WIDTH - 1)) begin
               state_next = ST_FIX;
            end
         end
         ST_FIX: begin
            busy       = 1'b1;
            state_next = ST_DONE;
         end
         ST_DONE: begin
            done       = 1'b1;
            state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
      if (flush) begin
         state_next = ST_IDLE;
      end
   end

   // Operand latching, iteration and HI/LO update
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_reg       <= '0;
         acc_hi_reg    <= '0;
         acc_lo_reg    <= '0;
         mag_op_reg    <= '0;
         op_is_div_reg <= 1'b0;
         neg_res_reg   <= 1'b0;
         neg_rem_reg   <= 1'b0;
         ovf_pend_reg  <= 1'b0;
         dz_pend_reg   <= 1'b0;
         ovf_reg       <= 1'b0;
         hi_reg        <= '0;
         lo_reg        <= '0;
      end else begin
         if (accept) begin
            cnt_reg       <= '0;
            op_is_div_reg <= in_div;
            neg_res_reg   <= sign_a ^ sign_b;
            neg_rem_reg   <= sign_a;
            ovf_pend_reg  <= (op_in == MD_DIV) && (req_a == {1'b1, {(WIDTH-1){1'b0}}})
                             && (req_b == '1);
            dz_pend_reg   <= dz_hit;
            ovf_reg       <= 1'b0;
            if (dz_hit) begin
               acc_hi_reg <= req_a;
               acc_lo_reg <= '1;
               mag_op_reg <= '0;
            end else if (in_div) begin
               acc_hi_reg <= '0;
               acc_lo_reg <= mag_a;
               mag_op_reg <= mag_b;
            end else begin
               acc_hi_reg <= '0;
               acc_lo_reg <= mag_b;
               mag_op_reg <= mag_a;
            end
         end else if ((state_reg == ST_RUN) && !flush) begin
            acc_hi_reg <= step_hi;
            acc_lo_reg <= step_lo;
            cnt_reg    <= cnt_reg + CW'(1);
         end

         // FIX loads the result; MTHI/MTLO only land in IDLE/DONE, so a
         // write in DONE naturally overrides the value loaded one edge earlier.
         if ((state_reg == ST_FIX) && !flush) begin
            hi_reg  <= res_hi;
            lo_reg  <= res_lo;
            ovf_reg <= ovf_pend_reg;
         end else if (wr_allowed) begin
            if (wr_hi_en) hi_reg <= wr_data;
            if (wr_lo_en) lo_reg <= wr_data;
         end
      end
   end

`ifdef MULDIV_DZ_EN
   logic dz_reg;
   always_ff @(posedge clk) begin
      if (rst) begin
         dz_reg <= 1'b0;
      end else if (accept) begin
         dz_reg <= 1'b0;
      end else if ((state_reg == ST_FIX) && !flush) begin
         dz_reg <= dz_pend_reg;
      end
   end
   assign dz = dz_reg;
`else
   assign dz = 1'b0;
`endif

   assign hi  = hi_reg;
   assign lo  = lo_reg;
   assign ovf = ovf_reg;

endmodule

// File: tb/tb_muldiv_hilo_ctrl.sv
// tb_muldiv_hilo_ctrl
//   Table-driven check of muldiv_hilo_ctrl: each vector runs one request
//   and compares HI/LO/ovf/dz, done latency and busy length against
//   hand-computed values, followed by sequences for flush and MTHI/MTLO.
//   Honours MULDIV_DZ_EN for the divide-by-zero expectations.
module tb_muldiv_hilo_ctrl;

   localparam int W = 32;
`ifdef MULDIV_DZ_EN
   localparam int   DZ_LAT = 2;
   localparam logic DZ_EXP = 1'b1;
`else
   localparam int   DZ_LAT = W + 2;
   localparam logic DZ_EXP = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst, flush, req_valid, req_ready;
   logic [1:0]    req_op;
   logic [W-1:0]  req_a, req_b, wr_data, hi, lo;
   logic          wr_hi_en, wr_lo_en, busy, done, ovf, dz;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   muldiv_hilo_ctrl #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_op    (req_op),
      .req_a     (req_a),
      .req_b     (req_b),
      .wr_hi_en  (wr_hi_en),
      .wr_lo_en  (wr_lo_en),
      .wr_data   (wr_data),
      .busy      (busy),
      .done      (done),
      .hi        (hi),
      .lo        (lo),
      .ovf       (ovf),
      .dz        (dz)
   );

   typedef struct {
      logic [1:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      logic         ovf;
      logic         dz;
      int           lat;
   } vec_t;

   localparam int NV = 11;
   vec_t vecs [NV];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Issue one request from IDLE and return in the cycle where done is
   // seen (or the cycle budget expires). lat counts cycles after accept.
   task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output int lat, output int bcnt);
      req_valid = 1'b1;
      req_op    = op;
      req_a     = a;
      req_b     = b;
      tick();
      req_valid = 1'b0;
      lat  = 1;
      bcnt = busy ? 1 : 0;
      while (!done && lat < 200) begin
         tick();
         lat++;
         if (busy) bcnt++;
      end
   endtask

   initial begin
      int lat, bcnt;
      logic seen_done;
      logic [W-1:0] prior_hi, prior_lo;

      //       op     a             b             hi            lo            ovf   dz      lat
      vecs[0]  = '{2'b00, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 1'b0,   W+2};
      vecs[1]  = '{2'b01, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE, 1'b0, 1'b0,   W+2};
      vecs[2]  = '{2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 1'b0,   W+2};
      vecs[3]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b1, 1'b0,   W+2};
      vecs[4]  = '{2'b11, 32'd100,      32'd0,        32'd100,      32'hFFFFFFFF, 1'b0, DZ_EXP, DZ_LAT};
      vecs[5]  = '{2'b00, 32'd2,        32'd3,        32'h00000000, 32'h00000006, 1'b0, 1'b0,   W+2};
      vecs[6]  = '{2'b11, 32'hFFFFFFFF, 32'h10,       32'h0000000F, 32'h0FFFFFFF, 1'b0, 1'b0,   W+2};
      vecs[7]  = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 1'b0,   W+2};
      vecs[8]  = '{2'b10, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 1'b0,   W+2};
      vecs[9]  = '{2'b10, 32'd0,        32'd5,        32'h00000000, 32'h00000000, 1'b0, 1'b0,   W+2};
      vecs[10] = '{2'b01, 32'h12345678, 32'h100,      32'h00000012, 32'h34567800, 1'b0, 1'b0,   W+2};

      rst = 1'b1; flush = 1'b0; req_valid = 1'b0; req_op = 2'b00;
      req_a = '0; req_b = '0; wr_hi_en = 1'b0; wr_lo_en = 1'b0; wr_data = '0;
      repeat (3) tick();
      chk("rst_hi", hi, 0);
      chk("rst_lo", lo, 0);
      chk("rst_ovf", ovf, 0);
      chk("rst_dz", dz, 0);
      chk("rst_done", done, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ready", req_ready, 1);
      rst = 1'b0;
      tick();

      for (int i = 0; i < NV; i++) begin
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, bcnt);
         $display("vec %0d op %0d a %h b %h -> hi %h lo %h ovf %0b dz %0b lat %0d busy %0d",
                  i, vecs[i].op, vecs[i].a, vecs[i].b, hi, lo, ovf, dz, lat, bcnt);
         chk($sformatf("v%0d_lat", i), 64'(lat), 64'(vecs[i].lat));
         chk($sformatf("v%0d_busy", i), 64'(bcnt), 64'(vecs[i].lat - 1));
         chk($sformatf("v%0d_hi", i), hi, vecs[i].hi);
         chk($sformatf("v%0d_lo", i), lo, vecs[i].lo);
         chk($sformatf("v%0d_ovf", i), ovf, vecs[i].ovf);
         chk($sformatf("v%0d_dz", i), dz, vecs[i].dz);
         tick();
         chk($sformatf("v%0d_ready", i), req_ready, 1);
      end

      // flush mid-RUN of a multu: back to IDLE, HI/LO untouched, no done
      prior_hi = vecs[NV-1].hi;
      prior_lo = vecs[NV-1].lo;
      req_valid = 1'b1; req_op = 2'b01; req_a = 32'd5; req_b = 32'd7;
      tick();
      req_valid = 1'b0;
      repeat (9) tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      $display("flush: ready %0b busy %0b hi %h lo %h", req_ready, busy, hi, lo);
      chk("flush_ready", req_ready, 1);
      chk("flush_busy", busy, 0);
      chk("flush_hi", hi, prior_hi);
      chk("flush_lo", lo, prior_lo);
      seen_done = done;
      repeat (40) begin
         tick();
         if (done) seen_done = 1'b1;
      end
      chk("flush_no_done", seen_done, 0);

      // mult 2x3 with an MTLO during RUN (dropped) and MTHI in DONE (wins)
      req_valid = 1'b1; req_op = 2'b00; req_a = 32'd2; req_b = 32'd3;
      tick();
      req_valid = 1'b0;
      lat = 1;
      while (!done && lat < 200) begin
         wr_lo_en = (lat == 5);
         wr_data  = 32'hDEAD;
         tick();
         lat++;
      end
      wr_lo_en = 1'b0;
      $display("mt seq: lat %0d hi %h lo %h", lat, hi, lo);
      chk("mt_lat", 64'(lat), 64'(W + 2));
      chk("mt_lo_run_dropped", lo, 32'd6);
      wr_hi_en = 1'b1; wr_data = 32'h1234;
      tick();
      wr_hi_en = 1'b0;
      $display("mthi in done: hi %h lo %h", hi, lo);
      chk("mthi_done_hi", hi, 32'h1234);
      chk("mthi_done_lo", lo, 32'd6);

      // MTLO in IDLE
      wr_lo_en = 1'b1; wr_data = 32'hCAFE;
      tick();
      wr_lo_en = 1'b0;
      $display("mtlo idle: hi %h lo %h", hi, lo);
      chk("mtlo_idle_lo", lo, 32'hCAFE);
      chk("mtlo_idle_hi", hi, 32'h1234);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
